// File: rtl/prescaler_pkg.sv
// prescaler_pkg: shared types and constants for the
// pixel-clock timebase prescaler.
package prescaler_pkg;

   typedef enum logic [1:0] {
      STOP = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_e;

   localparam int unsigned DIV_MIN       = 2;
   localparam int unsigned F_OSC_DEFAULT = 25175000;

endpackage

// File: rtl/prescaler_ctrl_if.sv
// prescaler_ctrl_if: divisor configuration handshake
// between config logic (master) and the prescaler (slave).
interface prescaler_ctrl_if #(
   parameter int unsigned WIDTH = 32
);

   logic             cfg_valid;
   logic [WIDTH-1:0] cfg_div;
   logic             cfg_ready;
   logic             cfg_err;

   modport master (
      output cfg_valid,
      output cfg_div,
      input  cfg_ready,
      input  cfg_err
   );

   modport slave (
      input  cfg_valid,
      input  cfg_div,
      output cfg_ready,
      output cfg_err
   );

endinterface

// File: rtl/div_counter.sv
// div_counter: divide-by-div counter with registered
// one-cycle tick and ~50% duty clkout.
module div_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             clr,
   input  logic [WIDTH-1:0] div,
   output logic [WIDTH-1:0] cnt,
   output logic             wrap,
   output logic             clkout,
   output logic             tick
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic             tick_q;
   logic             tick_d;
   logic             clkout_q;
   logic             clkout_d;

   // last count of the period; never true while cleared
   assign wrap = !clr && (cnt_q == div - WIDTH'(1));

   // next count, tick on wrap, clkout high in upper half
   always_comb begin
      cnt_d    = cnt_q + WIDTH'(1);
      tick_d   = wrap;
      clkout_d = !clr && (cnt_q >= (div >> 1));
      if (clr || wrap) begin
         cnt_d = '0;
      end
   end

   // counter and output registers
   always_ff @(posedge clkin) begin
      if (rst) begin
         cnt_q    <= '0;
         tick_q   <= 1'b0;
         clkout_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
         clkout_q <= clkout_d;
      end
   end

   assign cnt    = cnt_q;
   assign tick   = tick_q;
   assign clkout = clkout_q;

endmodule

// File: rtl/prescaler_ctrl.sv
// prescaler_ctrl: divisor FSM, cfg handshake and the
// pending/active divisor registers around div_counter.
module prescaler_ctrl
   import prescaler_pkg::*;
#(
   parameter int unsigned F_OSC       = F_OSC_DEFAULT,
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEFAULT_DIV = F_OSC / 1000
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             enable,
   prescaler_ctrl_if.slave  cfg,
   output logic             tick,
   output logic             clkout,
   output logic [WIDTH-1:0] active_div,
   output logic             pending
);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] act_q;
   logic [WIDTH-1:0] act_d;
   logic [WIDTH-1:0] pend_q;
   logic [WIDTH-1:0] pend_d;
   logic             ready_q;
   logic             ready_d;
   logic             err_q;
   logic             err_d;
   logic             pending_q;
   logic             pending_d;

   logic             xfer;
   logic             take;
   logic             clr;
   logic             wrap;
   logic [WIDTH-1:0] cnt;
   logic             unused_cnt;

   assign xfer = cfg.cfg_valid && ready_q;
   assign take = xfer && (cfg.cfg_div >= WIDTH'(DIV_MIN));
   assign clr  = !enable || (state_q == STOP);

   assign unused_cnt = ^cnt;

   div_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clkin  (clkin),
      .rst    (rst),
      .clr    (clr),
      .div    (act_q),
      .cnt    (cnt),
      .wrap   (wrap),
      .clkout (clkout),
      .tick   (tick)
   );

   // mode transitions and divisor hand-over at boundaries
   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      pend_d  = pend_q;
      unique case (state_q)
         STOP: begin
            if (take) begin
               act_d = cfg.cfg_div;
            end
            if (enable) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!enable) begin
               state_d = STOP;
               if (take) begin
                  act_d = cfg.cfg_div;
               end
            end else if (take) begin
               pend_d  = cfg.cfg_div;
               state_d = PEND;
            end
         end
         PEND: begin
            if (!enable) begin
               act_d   = pend_q;
               state_d = STOP;
            end else if (wrap) begin
               act_d   = pend_q;
               state_d = RUN;
            end
         end
         default: begin
            state_d = STOP;
         end
      endcase
      ready_d   = (state_d != PEND);
      pending_d = (state_d == PEND);
      err_d     = xfer && !take;
   end

   // control registers
   always_ff @(posedge clkin) begin
      if (rst) begin
         state_q   <= STOP;
         act_q     <= WIDTH'(DEFAULT_DIV);
         pend_q    <= '0;
         ready_q   <= 1'b1;
         err_q     <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         act_q     <= act_d;
         pend_q    <= pend_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
         pending_q <= pending_d;
      end
   end

   assign cfg.cfg_ready = ready_q;
   assign cfg.cfg_err   = err_q;
   assign active_div    = act_q;
   assign pending       = pending_q;

endmodule

// File: tb/tb_prescaler_ctrl.sv
// tb_prescaler_ctrl: directed plus random stimulus, checked
// every cycle against a behavioural period model.
module tb_prescaler_ctrl;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        tick;
   logic        clkout;
   logic [31:0] active_div;
   logic        pending;

   prescaler_ctrl_if #(.WIDTH(32)) cif ();

   prescaler_ctrl #(
      .F_OSC       (25175000),
      .WIDTH       (32),
      .DEFAULT_DIV (25175)
   ) dut (
      .clkin      (clk),
      .rst        (rst),
      .enable     (enable),
      .cfg        (cif),
      .tick       (tick),
      .clkout     (clkout),
      .active_div (active_div),
      .pending    (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d want %0d", nm, $time, act, exp);
      end
   endtask

   // model: position in the period, divisor in force, held divisor
   bit          m_run;
   logic [31:0] m_pos;
   logic [31:0] m_D;
   bit          m_pv;
   logic [31:0] m_pd;
   bit          m_tick;
   bit          m_clk;
   bit          m_err;
   bit          m_ready;
   bit          m_xfer;
   bit          m_legal;
   bit          m_last;

   always @(posedge clk) begin
      if (rst) begin
         m_run = 0; m_pos = 0; m_D = 25175; m_pv = 0; m_pd = 0;
         m_tick = 0; m_clk = 0; m_err = 0; m_ready = 1;
      end else begin
         m_xfer  = cif.cfg_valid && m_ready;
         m_legal = cif.cfg_div >= 2;
         m_last  = m_run && enable && (m_pos == m_D - 1);
         m_err   = m_xfer && !m_legal;
         m_tick  = m_last;
         m_clk   = m_run && enable && (m_pos >= m_D / 2);
         if (!enable) begin
            if (m_pv) m_D = m_pd;
            if (m_xfer && m_legal) m_D = cif.cfg_div;
            m_pv = 0; m_run = 0; m_pos = 0;
         end else if (!m_run) begin
            if (m_xfer && m_legal) m_D = cif.cfg_div;
            m_run = 1; m_pos = 0;
         end else begin
            if (m_last) begin
               m_pos = 0;
               if (m_pv) begin m_D = m_pd; m_pv = 0; end
            end else begin
               m_pos = m_pos + 1;
            end
            if (m_xfer && m_legal) begin m_pv = 1; m_pd = cif.cfg_div; end
         end
         m_ready = !m_pv;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_tick", 32'(tick), 32'(m_tick));
         chk("m_clkout", 32'(clkout), 32'(m_clk));
         chk("m_ready", 32'(cif.cfg_ready), 32'(m_ready));
         chk("m_err", 32'(cif.cfg_err), 32'(m_err));
         chk("m_pending", 32'(pending), 32'(m_pv));
         chk("m_active_div", active_div, m_D);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         cyc();
         n++;
         if (tick) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL wait_tick: no tick within 200 cycles");
   endtask

   task automatic offer(input logic [31:0] d);
      cif.cfg_valid = 1'b1;
      cif.cfg_div   = d;
      cyc();
      cif.cfg_valid = 1'b0;
   endtask

   int       n;
   logic [3:0] pat;
   int       r;

   initial begin
      rst = 1; enable = 0; cif.cfg_valid = 0; cif.cfg_div = 0;
      cyc(); cyc();
      chk_en = 1;
      chk("rst_active_div", active_div, 25175);
      chk("rst_ready", 32'(cif.cfg_ready), 1);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_clkout", 32'(clkout), 0);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_err", 32'(cif.cfg_err), 0);
      rst = 0;
      cyc();

      // STOP config to 4, then run
      offer(4);
      chk("stop_cfg_div4", active_div, 4);
      enable = 1;
      cyc();
      wait_tick(n); chk("first_period_d4", n, 4);
      pat = '0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         pat = {pat[2:0], clkout};
      end
      chk("clkout_pattern_d4", 32'(pat), 32'b0011);
      chk("tick_end_d4", 32'(tick), 1);

      // move to 6 at next boundary
      offer(6);
      wait_tick(n); chk("remain_d4", n, 3);
      chk("applied_d6", active_div, 6);
      wait_tick(n); chk("period_d6", n, 6);

      // offer 3 mid-period of D=6
      cyc();
      offer(3);
      chk("pend_ready0", 32'(cif.cfg_ready), 0);
      chk("pend_flag1", 32'(pending), 1);
      wait_tick(n); chk("old_period_finish", n, 4);
      chk("applied_d3", active_div, 3);
      chk("pend_cleared", 32'(pending), 0);
      wait_tick(n); chk("period_d3_a", n, 3);
      wait_tick(n); chk("period_d3_b", n, 3);

      // back to 4, then offer 5 on the wrap cycle
      offer(4);
      wait_tick(n); chk("remain_d3", n, 2);
      cyc(); cyc(); cyc();
      offer(5);
      chk("wrap_xfer_tick", 32'(tick), 1);
      chk("wrap_xfer_pend", 32'(pending), 1);
      chk("wrap_xfer_act", active_div, 4);
      wait_tick(n); chk("extra_d4_period", n, 4);
      chk("applied_d5", active_div, 5);
      wait_tick(n); chk("period_d5", n, 5);

      // illegal divisors
      offer(1);
      chk("err_div1", 32'(cif.cfg_err), 1);
      chk("err_div1_ready", 32'(cif.cfg_ready), 1);
      chk("err_div1_act", active_div, 5);
      cyc();
      chk("err_clear", 32'(cif.cfg_err), 0);
      offer(0);
      chk("err_div0", 32'(cif.cfg_err), 1);
      chk("err_div0_pend", 32'(pending), 0);
      wait_tick(n);
      wait_tick(n); chk("period_after_err", n, 5);

      // drop enable at cnt=2 with pending 7
      offer(7);
      chk("pend7", 32'(pending), 1);
      cyc();
      enable = 0;
      cyc();
      chk("stop_tick", 32'(tick), 0);
      chk("stop_clkout", 32'(clkout), 0);
      chk("stop_act7", active_div, 7);
      chk("stop_pend0", 32'(pending), 0);
      cyc(); cyc(); cyc();
      enable = 1;
      cyc();
      wait_tick(n); chk("reenable_d7", n, 7);

      // reset while pending mid-period
      cyc(); cyc();
      offer(9);
      chk("pend9", 32'(pending), 1);
      cyc();
      rst = 1;
      cyc();
      rst = 0;
      chk("rst2_act", active_div, 25175);
      chk("rst2_pend", 32'(pending), 0);
      chk("rst2_ready", 32'(cif.cfg_ready), 1);
      chk("rst2_tick", 32'(tick), 0);
      chk("rst2_clkout", 32'(clkout), 0);
      for (int i = 0; i < 20; i++) cyc();
      chk("rst2_act_kept", active_div, 25175);
      chk("rst2_no_tick", 32'(tick), 0);

      // random traffic
      enable = 0;
      cyc();
      offer(3);
      for (int i = 0; i < 4000; i++) begin
         enable = ($urandom_range(0, 99) < 94);
         cif.cfg_valid = ($urandom_range(0, 3) == 0);
         r = $urandom_range(0, 99);
         if (r < 10)      cif.cfg_div = $urandom_range(0, 1);
         else if (r < 11) cif.cfg_div = 32'hFFFF_FFFF;
         else             cif.cfg_div = $urandom_range(2, 9);
         cyc();
      end
      cif.cfg_valid = 0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
